// File: rtl/init_ram_port_ctrl.sv
// rtl/init_ram_port_ctrl.sv - request/response initiator and block-fill engine for a single-port sync RAM
`timescale 1ns/1ps
module init_ram_port_ctrl #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 10
) (
    input  logic                 PortAClk,
    input  logic                 PortARstN,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDRWIDTH-1:0] req_addr,
    input  logic [DATAWIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    input  logic                 fill_start,
    input  logic [ADDRWIDTH-1:0] fill_base,
    input  logic [ADDRWIDTH:0]   fill_len,
    input  logic [DATAWIDTH-1:0] fill_value,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_wdata,
    output logic                 ram_we,
    input  logic [DATAWIDTH-1:0] ram_rdata
);

    localparam logic [ADDRWIDTH:0] MEMDEPTH = {1'b1, {ADDRWIDTH{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CAPT, S_RESP, S_FILL} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ADDRWIDTH-1:0] r_addr;
    logic [DATAWIDTH-1:0] r_wdata;
    logic [ADDRWIDTH-1:0] r_fill_addr;
    logic [DATAWIDTH-1:0] r_fill_value;
    logic [ADDRWIDTH:0]   r_rem;
    logic [DATAWIDTH-1:0] r_rsp_rdata;
    logic                 r_done;
    logic                 w_fill_go;
    logic                 w_fill_wr;
    logic                 w_hs;

    // Gating with reset keeps the RAM port quiet while reset is held.
    assign req_ready = (r_state == S_IDLE) & ~fill_start & PortARstN;
    assign w_hs      = req_ready & req_valid;
    assign w_fill_go = (r_state == S_IDLE) & fill_start;
    assign w_fill_wr = (r_state == S_FILL) & (r_rem != '0);

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign fill_busy = (r_state == S_FILL);
    assign fill_done = r_done;

    always_comb begin
        w_next    = r_state;
        ram_we    = 1'b0;
        ram_addr  = r_addr;
        ram_wdata = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_fill_go) begin
                    w_next = S_FILL;
                end else if (w_hs) begin
                    ram_addr  = req_addr;
                    ram_wdata = req_wdata;
                    ram_we    = req_write;
                    w_next    = S_CAPT;
                end
            end
            S_CAPT: w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            S_FILL: begin
                if (w_fill_wr) begin
                    ram_we    = 1'b1;
                    ram_addr  = r_fill_addr;
                    ram_wdata = r_fill_value;
                end
                if (r_rem <= 1) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge PortAClk or negedge PortARstN) begin
        if (!PortARstN) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_fill_addr  <= '0;
            r_fill_value <= '0;
            r_rem        <= '0;
            r_rsp_rdata  <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_addr  <= ram_addr;
            r_wdata <= ram_wdata;
            r_done  <= (r_state == S_FILL) && (w_next == S_IDLE);
            if (w_fill_go) begin
                r_fill_addr  <= fill_base;
                r_fill_value <= fill_value;
                r_rem        <= (fill_len > MEMDEPTH) ? MEMDEPTH : fill_len;
            end else if (w_fill_wr) begin
                r_fill_addr <= r_fill_addr + 1'b1;
                r_rem       <= r_rem - 1'b1;
            end
            if (r_state == S_CAPT) r_rsp_rdata <= ram_rdata;
        end
    end

endmodule
